jelly3_img_demosaic_acpi_rb_pipe: RTL and testbench
===================================================

Name: jelly3_img_demosaic_acpi_rb_pipe

Overview:
- Final ACPI demosaic stage. Consumes the {G, RAW} plane produced by the ACPI G-interpolation stage and outputs full RGB per pixel.
- Input is a 3x3 window supplied by a jelly2_img_blk_buffer (M=N=3, REFLECT_101) placed in front of it.
- Tracks the Bayer phase from frame/line markers and interpolates R/B using colour-difference and diagonal-gradient selection.
- Fixed 4-stage pipeline; sideband signals are delayed in lockstep.

Parameters:
- DATA_BITS, 10, width of each RAW and G sample.
- USER_BITS, 1, width of the user sideband.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cke  in  1  clock enable; 0 freezes all state
- param_phase  in  2  Bayer phase: [0] column parity, [1] row parity
- s_img_row_first/row_last/col_first/col_last/de  in  1 each  frame markers of the window centre
- s_img_user  in  USER_BITS  user sideband
- s_img_data  in  9*2*DATA_BITS  window [y][x], y,x in 0..2, centre [1][1]; each element is {g, raw}, with g in the upper DATA_BITS
- s_img_valid  in  1  window valid
- m_img_row_first/row_last/col_first/col_last/de  out  1 each  delayed markers
- m_img_user  out  USER_BITS  delayed user
- m_img_raw  out  DATA_BITS  centre raw
- m_img_r, m_img_g, m_img_b  out  DATA_BITS each  interpolated colours
- m_img_valid  out  1  output valid

Behaviour:
- Reset (reset=0, asynchronous): every pipeline register and output clears to 0. Phase counters and latched phase clear to 0. Takes effect immediately, including mid-frame.
- cke=0: no register changes. Outputs hold.
- All logic below advances only when cke=1.

Phase tracking (input side, on s_img_valid=1):
- If col_first: x=0. Then, if row_first: y=0 and phase_lat=param_phase; otherwise y toggles.
- If not col_first: x toggles.
- param_phase is sampled only at frame start; mid-frame changes are ignored until the next frame.
- Colour code c = {y^phase_lat[1], x^phase_lat[0]}: 00=R, 01=Gr (R row), 10=Gb (B row), 11=B.
- The code for the current pixel uses post-update x/y.

Arithmetic:
- Signed, DATA_BITS+4 bits; /2 and /4 are arithmetic shift right (floor). Gc = centre g, Rc = centre raw.
- Horizontal colour difference: H = Gc + ((raw[1][0]-g[1][0]) + (raw[1][2]-g[1][2])) >>> 1. Vertical V uses [0][1] and [2][1].
- Diagonal colour difference: Dp = |raw[0][0]-raw[2][2]| + |2Gc-g[0][0]-g[2][2]|; Dn = |raw[0][2]-raw[2][0]| + |2Gc-g[0][2]-g[2][0]|.
- Dp<Dn: X = Gc + ((raw00-g00)+(raw22-g22)) >>> 1.
- Dn<Dp: X = Gc + ((raw02-g02)+(raw20-g20)) >>> 1.
- Equal: X = Gc + (sum of four diagonal (raw-g)) >>> 2.

Per colour code:
- R: r=Rc, g=Gc, b=X.
- B: b=Rc, g=Gc, r=X.
- Gr: r=H, b=V, g=Gc.
- Gb: r=V, b=H, g=Gc.
- Direct and interpolated results clip to [0, 2^DATA_BITS-1].

Pipeline:
- S1: differences, colour code.
- S2: absolute values, Dp/Dn.
- S3: select and sum.
- S4: shift, clip, mux, register outputs.
- Latency is exactly 4 cke-enabled cycles from s_img_* to m_img_*.
- The sideband delay line is also 4 and carries valid, markers, de and user unchanged.
- Invalid cycles still shift the pipeline, so data positions stay aligned. Phase counters do not change on invalid cycles.

Boundary conditions:
- Single-column frame: col_first and col_last both set, x=0 every line.
- Single-row frame: y stays 0.
- Back-to-back frames with no gap are handled by the row_first&col_first re-latch.

Test Plan:
- Flat field: every window element {g=512, raw=512}, phase=0 -> r=g=b=512 exactly 4 cycles after input, markers aligned.
- Phase sweep: 4x4 frame with phase=0..3 and a distinct raw per pixel -> at pixel (0,0) the direct output equals centre raw and lands on r for phase 0, Gr for 1 (g=Gc), Gb for 2, b for 3. A param_phase change mid-frame has no effect until the next row_first.
- Gr horizontal: Gc=300, [1][0]={200,400}, [1][2]={220,420}, verticals {300,300} -> r=500, b=300.
- Diagonal select at B pixel: Gc=500, [0][0]={500,100}, [2][2]={500,100}, [0][2]={500,900}, [2][0]={500,50} -> Dp=0 < Dn, r=100. Setting all four diagonals raw=100 -> tie path, r=100.
- Clipping: Gr pixel with Gc=10 and left/right raw-g of -100 each -> r=0. Gc=1000 with +200 each -> r=1023.
- Stall/reset: hold cke=0 for 3 cycles mid-stream -> outputs frozen, total latency 4 enabled cycles. Assert reset mid-frame -> m_img_valid=0 and all outputs 0 immediately; the next frame's first output is correct.

Source files
------------

// File: rtl/jelly3_img_demosaic_acpi_rb_pipe_if.sv
// Stream buses around the ACPI R/B stage: the 3x3 {G, RAW} window going in
// and the RGB pixel coming out, each carrying the centre's frame markers.

interface jelly3_img_demosaic_acpi_rb_pipe_win_if #(
    parameter int DATA_BITS = 10,
    parameter int USER_BITS = 1
) ();
    logic                       row_first;
    logic                       row_last;
    logic                       col_first;
    logic                       col_last;
    logic                       de;
    logic [USER_BITS-1:0]       user;
    logic [9*2*DATA_BITS-1:0]   data;
    logic                       valid;

    modport master (
        output row_first, row_last, col_first, col_last, de, user, data, valid
    );

    modport slave (
        input  row_first, row_last, col_first, col_last, de, user, data, valid
    );
endinterface

interface jelly3_img_demosaic_acpi_rb_pipe_rgb_if #(
    parameter int DATA_BITS = 10,
    parameter int USER_BITS = 1
) ();
    logic                       row_first;
    logic                       row_last;
    logic                       col_first;
    logic                       col_last;
    logic                       de;
    logic [USER_BITS-1:0]       user;
    logic [DATA_BITS-1:0]       raw;
    logic [DATA_BITS-1:0]       r;
    logic [DATA_BITS-1:0]       g;
    logic [DATA_BITS-1:0]       b;
    logic                       valid;

    modport master (
        output row_first, row_last, col_first, col_last, de, user, raw, r, g, b, valid
    );

    modport slave (
        input  row_first, row_last, col_first, col_last, de, user, raw, r, g, b, valid
    );
endinterface

// File: rtl/jelly3_img_demosaic_acpi_rb_pipe.sv
// Final ACPI demosaic stage: rebuilds R and B around the interpolated G plane
// using colour differences and diagonal-gradient selection, four cycles deep.

module jelly3_img_demosaic_acpi_rb_pipe #(
    parameter int DATA_BITS = 10,
    parameter int USER_BITS = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    cke,
    input  logic [1:0]                              param_phase,
    jelly3_img_demosaic_acpi_rb_pipe_win_if.slave   s_img,
    jelly3_img_demosaic_acpi_rb_pipe_rgb_if.master  m_img
);
    localparam int W      = DATA_BITS + 4;
    localparam int PAD    = W - DATA_BITS;
    localparam int SIDE_W = 5 + USER_BITS;
    localparam logic signed [W-1:0] PIX_MAX = W'((1 << DATA_BITS) - 1);

    localparam logic [1:0] CODE_R  = 2'b00;
    localparam logic [1:0] CODE_GR = 2'b01;
    localparam logic [1:0] CODE_B  = 2'b11;

    function automatic logic signed [W-1:0] abs_s(input logic signed [W-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [DATA_BITS-1:0] clip(input logic signed [W-1:0] v);
        if (v < 0)       return '0;
        if (v > PIX_MAX) return '1;
        return v[DATA_BITS-1:0];
    endfunction

    logic signed [W-1:0] win_g   [9];
    logic signed [W-1:0] win_raw [9];

    for (genvar i = 0; i < 9; i++) begin : g_win
        assign win_raw[i] = signed'({{PAD{1'b0}}, s_img.data[i*2*DATA_BITS +: DATA_BITS]});
        assign win_g[i]   = signed'({{PAD{1'b0}}, s_img.data[i*2*DATA_BITS+DATA_BITS +: DATA_BITS]});
    end

    // Bayer position of the window centre; the code is taken after this pixel's update
    logic       x_pos, y_pos, x_next, y_next;
    logic [1:0] phase_lat, phase_next, code;

    always_comb begin
        x_next     = ~x_pos;
        y_next     = y_pos;
        phase_next = phase_lat;
        if (s_img.col_first) begin
            x_next = 1'b0;
            if (s_img.row_first) begin
                y_next     = 1'b0;
                phase_next = param_phase;
            end else begin
                y_next = ~y_pos;
            end
        end
        code = {y_next ^ phase_next[1], x_next ^ phase_next[0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_pos     <= 1'b0;
            y_pos     <= 1'b0;
            phase_lat <= 2'b00;
        end else if (cke && s_img.valid) begin
            x_pos     <= x_next;
            y_pos     <= y_next;
            phase_lat <= phase_next;
        end
    end

    // Stage 1: colour differences of every neighbour and diagonal raw/G gradients
    logic                   vld_p1;
    logic [SIDE_W-1:0]      side_p1;
    logic [1:0]             code_p1;
    logic [DATA_BITS-1:0]   raw_p1;
    logic signed [W-1:0]    gc_p1, dl_p1, dr_p1, du_p1, dd_p1;
    logic signed [W-1:0]    d00_p1, d22_p1, d02_p1, d20_p1;
    logic signed [W-1:0]    rdp_p1, rdn_p1, gdp_p1, gdn_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;   side_p1 <= '0;     code_p1 <= '0;     raw_p1  <= '0;
            gc_p1   <= '0;     dl_p1   <= '0;     dr_p1   <= '0;     du_p1   <= '0;
            dd_p1   <= '0;     d00_p1  <= '0;     d22_p1  <= '0;     d02_p1  <= '0;
            d20_p1  <= '0;     rdp_p1  <= '0;     rdn_p1  <= '0;     gdp_p1  <= '0;
            gdn_p1  <= '0;
        end else if (cke) begin
            vld_p1  <= s_img.valid;
            side_p1 <= {s_img.row_first, s_img.row_last, s_img.col_first,
                        s_img.col_last, s_img.de, s_img.user};
            code_p1 <= code;
            raw_p1  <= s_img.data[4*2*DATA_BITS +: DATA_BITS];
            gc_p1   <= win_g[4];
            dl_p1   <= win_raw[3] - win_g[3];
            dr_p1   <= win_raw[5] - win_g[5];
            du_p1   <= win_raw[1] - win_g[1];
            dd_p1   <= win_raw[7] - win_g[7];
            d00_p1  <= win_raw[0] - win_g[0];
            d22_p1  <= win_raw[8] - win_g[8];
            d02_p1  <= win_raw[2] - win_g[2];
            d20_p1  <= win_raw[6] - win_g[6];
            rdp_p1  <= win_raw[0] - win_raw[8];
            rdn_p1  <= win_raw[2] - win_raw[6];
            gdp_p1  <= (win_g[4] <<< 1) - win_g[0] - win_g[8];
            gdn_p1  <= (win_g[4] <<< 1) - win_g[2] - win_g[6];
        end
    end

    // Stage 2: diagonal gradient magnitudes
    logic                   vld_p2;
    logic [SIDE_W-1:0]      side_p2;
    logic [1:0]             code_p2;
    logic [DATA_BITS-1:0]   raw_p2;
    logic signed [W-1:0]    gc_p2, dl_p2, dr_p2, du_p2, dd_p2;
    logic signed [W-1:0]    d00_p2, d22_p2, d02_p2, d20_p2, dp_p2, dn_p2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2  <= 1'b0;   side_p2 <= '0;     code_p2 <= '0;     raw_p2  <= '0;
            gc_p2   <= '0;     dl_p2   <= '0;     dr_p2   <= '0;     du_p2   <= '0;
            dd_p2   <= '0;     d00_p2  <= '0;     d22_p2  <= '0;     d02_p2  <= '0;
            d20_p2  <= '0;     dp_p2   <= '0;     dn_p2   <= '0;
        end else if (cke) begin
            vld_p2  <= vld_p1;
            side_p2 <= side_p1;
            code_p2 <= code_p1;
            raw_p2  <= raw_p1;
            gc_p2   <= gc_p1;
            dl_p2   <= dl_p1;
            dr_p2   <= dr_p1;
            du_p2   <= du_p1;
            dd_p2   <= dd_p1;
            d00_p2  <= d00_p1;
            d22_p2  <= d22_p1;
            d02_p2  <= d02_p1;
            d20_p2  <= d20_p1;
            dp_p2   <= abs_s(rdp_p1) + abs_s(gdp_p1);
            dn_p2   <= abs_s(rdn_p1) + abs_s(gdn_p1);
        end
    end

    // Stage 3: pick the flatter diagonal (both on a tie) and sum the differences
    logic                   vld_p3;
    logic [SIDE_W-1:0]      side_p3;
    logic [1:0]             code_p3;
    logic [DATA_BITS-1:0]   raw_p3;
    logic signed [W-1:0]    gc_p3, h_sum_p3, v_sum_p3, x_sum_p3;
    logic                   x_tie_p3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p3   <= 1'b0;  side_p3  <= '0;    code_p3  <= '0;    raw_p3   <= '0;
            gc_p3    <= '0;    h_sum_p3 <= '0;    v_sum_p3 <= '0;    x_sum_p3 <= '0;
            x_tie_p3 <= 1'b0;
        end else if (cke) begin
            vld_p3   <= vld_p2;
            side_p3  <= side_p2;
            code_p3  <= code_p2;
            raw_p3   <= raw_p2;
            gc_p3    <= gc_p2;
            h_sum_p3 <= dl_p2 + dr_p2;
            v_sum_p3 <= du_p2 + dd_p2;
            if (dp_p2 < dn_p2) begin
                x_sum_p3 <= d00_p2 + d22_p2;
                x_tie_p3 <= 1'b0;
            end else if (dn_p2 < dp_p2) begin
                x_sum_p3 <= d02_p2 + d20_p2;
                x_tie_p3 <= 1'b0;
            end else begin
                x_sum_p3 <= d00_p2 + d22_p2 + d02_p2 + d20_p2;
                x_tie_p3 <= 1'b1;
            end
        end
    end

    // Stage 4: halve/quarter the sums, add back G, clip and route by colour code
    logic signed [W-1:0]    h_val, v_val, x_val, c_val;
    logic [DATA_BITS-1:0]   r_next, g_next, b_next;

    always_comb begin
        h_val  = gc_p3 + (h_sum_p3 >>> 1);
        v_val  = gc_p3 + (v_sum_p3 >>> 1);
        x_val  = gc_p3 + (x_tie_p3 ? (x_sum_p3 >>> 2) : (x_sum_p3 >>> 1));
        c_val  = signed'({{PAD{1'b0}}, raw_p3});
        g_next = clip(gc_p3);
        r_next = clip(v_val);
        b_next = clip(h_val);
        case (code_p3)
            CODE_R: begin
                r_next = clip(c_val);
                b_next = clip(x_val);
            end
            CODE_B: begin
                r_next = clip(x_val);
                b_next = clip(c_val);
            end
            CODE_GR: begin
                r_next = clip(h_val);
                b_next = clip(v_val);
            end
            default: ;
        endcase
    end

    logic                   vld_p4;
    logic [SIDE_W-1:0]      side_p4;
    logic [DATA_BITS-1:0]   raw_p4, r_p4, g_p4, b_p4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p4  <= 1'b0;
            side_p4 <= '0;
            raw_p4  <= '0;
            r_p4    <= '0;
            g_p4    <= '0;
            b_p4    <= '0;
        end else if (cke) begin
            vld_p4  <= vld_p3;
            side_p4 <= side_p3;
            raw_p4  <= raw_p3;
            r_p4    <= r_next;
            g_p4    <= g_next;
            b_p4    <= b_next;
        end
    end

    assign {m_img.row_first, m_img.row_last, m_img.col_first,
            m_img.col_last, m_img.de, m_img.user} = side_p4;
    assign m_img.raw   = raw_p4;
    assign m_img.r     = r_p4;
    assign m_img.g     = g_p4;
    assign m_img.b     = b_p4;
    assign m_img.valid = vld_p4;

endmodule

// File: tb/tb_jelly3_img_demosaic_acpi_rb_pipe.sv
// Bench for the ACPI R/B stage: table-driven single-pixel frames, multi-pixel
// frames with a queue scoreboard, plus stall, latency and reset sequences.

module tb_jelly3_img_demosaic_acpi_rb_pipe;
    localparam int DB    = 10;
    localparam int UB    = 1;
    localparam int WIN_W = 9 * 2 * DB;

    typedef struct packed {
        logic          rf, rl, cf, cl, de;
        logic [UB-1:0] user;
        logic [DB-1:0] raw, r, g, b;
    } out_t;

    typedef struct {
        string            name;
        logic [WIN_W-1:0] data;
        logic [1:0]       phase;
        logic [DB-1:0]    er, eg, eb;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cke = 1'b0;
    logic [1:0] param_phase = 2'd0;
    int         checks = 0;
    int         errors = 0;
    out_t       sb[$];

    always #5 clk = ~clk;

    jelly3_img_demosaic_acpi_rb_pipe_win_if #(.DATA_BITS(DB), .USER_BITS(UB)) s_img ();
    jelly3_img_demosaic_acpi_rb_pipe_rgb_if #(.DATA_BITS(DB), .USER_BITS(UB)) m_img ();

    jelly3_img_demosaic_acpi_rb_pipe #(.DATA_BITS(DB), .USER_BITS(UB)) dut (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .param_phase (param_phase),
        .s_img       (s_img),
        .m_img       (m_img)
    );

    function automatic logic [WIN_W-1:0] flat(input int g, input int raw);
        logic [WIN_W-1:0] d;
        d = '0;
        for (int i = 0; i < 9; i++) begin
            d[i*2*DB +: DB]    = DB'(raw);
            d[i*2*DB+DB +: DB] = DB'(g);
        end
        return d;
    endfunction

    function automatic logic [WIN_W-1:0] put(input logic [WIN_W-1:0] din, input int y, input int x,
                                             input int g, input int raw);
        logic [WIN_W-1:0] d;
        d = din;
        d[(y*3+x)*2*DB +: DB]    = DB'(raw);
        d[(y*3+x)*2*DB+DB +: DB] = DB'(g);
        return d;
    endfunction

    // B/R-site window: G flat at 500, centre raw 600, four diagonal raws given
    function automatic logic [WIN_W-1:0] diag(input int a00, input int a22, input int a02, input int a20);
        logic [WIN_W-1:0] d;
        d = put(flat(500, 500), 1, 1, 500, 600);
        d = put(d, 0, 0, 500, a00);
        d = put(d, 2, 2, 500, a22);
        d = put(d, 0, 2, 500, a02);
        d = put(d, 2, 0, 500, a20);
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [WIN_W-1:0] d, input logic [1:0] ph,
                         input logic rf, input logic rl, input logic cf, input logic cl,
                         input logic vld, input logic [UB-1:0] user,
                         input int er, input int eg, input int eb);
        s_img.data      = d;
        param_phase     = ph;
        s_img.row_first = rf;
        s_img.row_last  = rl;
        s_img.col_first = cf;
        s_img.col_last  = cl;
        s_img.de        = vld;
        s_img.user      = user;
        s_img.valid     = vld;
        cke             = 1'b1;
        if (vld) sb.push_back(out_t'{rf, rl, cf, cl, vld, user, d[4*2*DB +: DB], DB'(er), DB'(eg), DB'(eb)});
        @(posedge clk); #1;
    endtask

    // Flat window (G=raw=400) with a distinct centre raw v: neighbours interpolate to 400
    task automatic pix(input int code, input int v, input logic [1:0] ph,
                       input logic rf, input logic rl, input logic cf, input logic cl,
                       input logic [UB-1:0] user);
        drive(put(flat(400, 400), 1, 1, 400, v), ph, rf, rl, cf, cl, 1'b1, user,
              (code == 0) ? v : 400, 400, (code == 3) ? v : 400);
    endtask

    // Invalid cycles carry frame-start markers and a foreign phase that must be ignored
    task automatic idle(input int n, input logic en);
        s_img.valid     = 1'b0;
        s_img.de        = 1'b0;
        s_img.row_first = 1'b1;
        s_img.col_first = 1'b1;
        param_phase     = 2'd3;
        cke             = en;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1, 1'b1);
        chk("sb_drain", 64'(sb.size()), 64'd0);
        idle(2, 1'b1);
    endtask

    function automatic int code_of(input int p, input int i, input int j);
        return (((i & 1) ^ ((p >> 1) & 1)) << 1) | ((j & 1) ^ (p & 1));
    endfunction

    initial begin : monitor
        logic en;
        out_t act;
        out_t e;
        forever begin
            @(posedge clk);
            en = cke && reset;
            @(negedge clk);
            if (en && m_img.valid) begin
                act = {m_img.row_first, m_img.row_last, m_img.col_first, m_img.col_last,
                       m_img.de, m_img.user, m_img.raw, m_img.r, m_img.g, m_img.b};
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty actual=%0h required=no output", act);
                end else begin
                    e = sb.pop_front();
                    chk("sb", 64'(act), 64'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tv[14];

        s_img.data = '0;  s_img.valid = 1'b0; s_img.de = 1'b0; s_img.user = '0;
        s_img.row_first = 1'b0; s_img.row_last = 1'b0;
        s_img.col_first = 1'b0; s_img.col_last = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(m_img.valid), 64'd0);
        chk("rst_data", 64'({m_img.raw, m_img.r, m_img.g, m_img.b}), 64'd0);
        reset = 1'b1;
        idle(1, 1'b1);

        tv[0]  = '{"flat_r",    flat(512, 512), 2'd0, 10'd512, 10'd512, 10'd512};
        tv[1]  = '{"flat_b",    flat(512, 512), 2'd3, 10'd512, 10'd512, 10'd512};
        tv[2]  = '{"gr_h",      put(put(flat(300, 300), 1, 0, 200, 400), 1, 2, 220, 420), 2'd1, 10'd500, 10'd300, 10'd300};
        tv[3]  = '{"gb_h",      put(put(flat(300, 300), 1, 0, 200, 400), 1, 2, 220, 420), 2'd2, 10'd300, 10'd300, 10'd500};
        tv[4]  = '{"gr_v",      put(put(flat(300, 300), 0, 1, 100, 200), 2, 1, 100, 300), 2'd1, 10'd300, 10'd300, 10'd450};
        tv[5]  = '{"gb_v",      put(put(flat(300, 300), 0, 1, 100, 200), 2, 1, 100, 300), 2'd2, 10'd450, 10'd300, 10'd300};
        tv[6]  = '{"h_floor",   put(flat(300, 300), 1, 0, 300, 299), 2'd1, 10'd299, 10'd300, 10'd300};
        tv[7]  = '{"diag_p_b",  diag(100, 100, 900, 50), 2'd3, 10'd100, 10'd500, 10'd600};
        tv[8]  = '{"diag_p_r",  diag(100, 100, 900, 50), 2'd0, 10'd600, 10'd500, 10'd100};
        tv[9]  = '{"diag_n_b",  diag(900, 50, 100, 100), 2'd3, 10'd100, 10'd500, 10'd600};
        tv[10] = '{"diag_eq_b", diag(100, 100, 100, 100), 2'd3, 10'd100, 10'd500, 10'd600};
        tv[11] = '{"diag_tie",  diag(100, 300, 600, 800), 2'd3, 10'd450, 10'd500, 10'd600};
        tv[12] = '{"clip_lo",   put(put(flat(10, 10), 1, 0, 200, 100), 1, 2, 200, 100), 2'd1, 10'd0, 10'd10, 10'd10};
        tv[13] = '{"clip_hi",   put(put(flat(1000, 1000), 1, 0, 200, 400), 1, 2, 200, 400), 2'd1, 10'd1023, 10'd1000, 10'd1000};

        // Each vector is a one-pixel frame, so param_phase selects its colour directly
        for (int k = 0; k < 14; k++)
            drive(tv[k].data, tv[k].phase, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'(k),
                  int'(tv[k].er), int'(tv[k].eg), int'(tv[k].eb));
        drain();

        // Back-to-back 4x4 frames per phase; param_phase moves mid-frame and must be ignored
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    pix(code_of(p, i, j), 100 + 64*p + 4*i + j,
                        (i == 0 && j == 0) ? 2'(p) : 2'(p + 1 + i),
                        i == 0, i == 3, j == 0, j == 3, 1'(j));
                    if (i == 2 && j == 1) idle(1, 1'b1);
                end

        for (int i = 0; i < 3; i++)
            pix(code_of(1, i, 0), 200 + i, (i == 0) ? 2'd1 : 2'd2, i == 0, i == 2, 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++)
            pix(code_of(0, 0, j), 250 + j, (j == 0) ? 2'd0 : 2'd2, 1'b1, 1'b1, j == 0, j == 2, 1'b1);
        drain();

        // Latency across a 3-cycle stall, then outputs held while cke is low
        drive(flat(512, 512), 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 512, 512, 512);
        chk("lat_e1", 64'(m_img.valid), 64'd0);
        idle(1, 1'b1);
        chk("lat_e2", 64'(m_img.valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            idle(1, 1'b0);
            chk("lat_stall", 64'(m_img.valid), 64'd0);
        end
        idle(1, 1'b1);
        chk("lat_e3", 64'(m_img.valid), 64'd0);
        idle(1, 1'b1);
        chk("lat_e4", 64'(m_img.valid), 64'd1);
        chk("lat_e4_r", 64'(m_img.r), 64'd512);
        for (int k = 0; k < 3; k++) begin
            idle(1, 1'b0);
            chk("hold_valid", 64'(m_img.valid), 64'd1);
            chk("hold_rgb", 64'({m_img.r, m_img.g, m_img.b}), 64'({10'd512, 10'd512, 10'd512}));
        end
        idle(1, 1'b1);
        chk("lat_after", 64'(m_img.valid), 64'd0);
        drain();

        // Asynchronous reset mid-frame with pixels in flight
        for (int j = 0; j < 5; j++)
            pix(code_of(3, 0, j), 700 + j, 2'd3, 1'b1, 1'b0, j == 0, j == 4, 1'b1);
        chk("pre_rst_valid", 64'(m_img.valid), 64'd1);
        #1;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 64'(m_img.valid), 64'd0);
        chk("mid_rst_data", 64'({m_img.raw, m_img.r, m_img.g, m_img.b}), 64'd0);
        chk("mid_rst_side", 64'({m_img.row_first, m_img.row_last, m_img.col_first,
                                 m_img.col_last, m_img.de, m_img.user}), 64'd0);
        idle(2, 1'b1);
        reset = 1'b1;
        idle(1, 1'b1);
        drive(tv[2].data, tv[2].phase, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
              int'(tv[2].er), int'(tv[2].eg), int'(tv[2].eb));
        drive(tv[7].data, tv[7].phase, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              int'(tv[7].er), int'(tv[7].eg), int'(tv[7].eb));
        drive(tv[13].data, tv[13].phase, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
              int'(tv[13].er), int'(tv[13].eg), int'(tv[13].eb));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
